instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Byte-serial program loader: the write side of instruction memory, which the CPU only ever reads.
//  Receives a length-prefixed byte stream (from a UART/host), assembles little-endian 32-bit words,
//  and writes them to instruction memory at consecutive word addresses. Holds the CPU in reset
//  until the load completes.
// PARAMETERS
//  WIDTH      32            data/address width; matches CPU WIDTH
//  BASE_ADDR  32'hBFC00000  byte address of the first written word (CPU reset PC)
//  MAX_WORDS  1024          largest accepted program, in words
// PORTS
//  CLK         in   1      system clock, single clock domain
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      one-cycle pulse; begins a load when in IDLE, DONE or ERR
//  byte_valid  in   1      byte_data is valid this cycle
//  byte_data   in   8      stream byte
//  byte_ready  out  1      loader accepts a byte this cycle (transfer = valid & ready)
//  mem_we      out  1      instruction-memory write strobe, one-cycle pulse per word
//  mem_addr    out  WIDTH  byte address of the write, BASE_ADDR + 4*index
//  mem_wdata   out  WIDTH  word being written
//  cpu_rst     out  1      hold the CPU in reset; high except in DONE
//  done        out  1      load completed successfully (level)
//  err         out  1      load aborted (level)
// BEHAVIOUR
//  - Reset values: byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, done=0, err=0;
//    state=IDLE; all counters and the partial word are cleared.
//  - Stream format: N[7:0], N[15:8], then N words, least significant byte first.
//  - FSM states: IDLE, LEN0, LEN1, DATA, CHK (only with the macro), DONE, ERR.
//    IDLE -start-> LEN0 -byte-> LEN1 -byte-> (N==0 ? DONE : N>MAX_WORDS ? ERR : DATA).
//    DATA -4th byte of word N-1-> DONE (or CHK). DONE/ERR -start-> LEN0; entering LEN0 clears done/err
//    and drives cpu_rst=1 in the same cycle.
//  - byte_ready=1 in LEN0, LEN1, DATA and CHK; 0 otherwise. No byte is dropped, and the stream
//    may stall at any byte.
//  - A byte counter (2 bits) shifts each byte into the lane for its position. On the edge that
//    accepts the 4th byte, mem_wdata and mem_addr are registered and mem_we=1 for exactly the
//    next cycle (one cycle of latency). The address then advances by 4. A 16-bit word counter
//    compares against N.
//  - start outside IDLE/DONE/ERR is ignored. A byte_valid with byte_ready=0 is not consumed.
//  - An asynchronous rst in the middle of a load discards the partial word. Memory already
//    written is left unchanged. cpu_rst returns to 1.
//  - cpu_rst is a registered output: 0 only while the state is DONE.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after the last data word the loader enters CHK and accepts one
//    byte. If that byte equals the XOR of all payload bytes (length bytes excluded), go to DONE;
//    otherwise go to ERR (the words already written remain). N==0 goes to CHK with an expected
//    value of 8'h00.
//  LOADER_CHECKSUM_EN undefined: there is no CHK state and no XOR register. The last word goes
//    directly to DONE.
// STRUCTURE
//  loader_pkg: state enum loader_state_t, localparam BYTES_PER_WORD=4, default BASE_ADDR constant.
//  Sub-module word_assembler: byte shift-in, lane count and word_valid pulse.
//  The top level holds the FSM, counters and address generation.
// TESTING
//  - Reset then start, stream 01 00 13 05 10 00 -> one mem_we pulse, addr=BFC00000, wdata=00100513;
//    then done=1, cpu_rst=0.
//  - N=3, byte_valid toggled randomly -> exactly 3 pulses at BFC00000/04/08 with the correct words;
//    no byte lost.
//  - N=0 -> DONE with no mem_we pulse. N=MAX_WORDS+1 (01 04) -> err=1, no writes, cpu_rst=1.
//  - rst asserted after 2 bytes of word 1 -> every output takes its reset value immediately.
//    A restart loads correctly from BFC00000.
//  - From DONE, start -> cpu_rst=1 and done=0 the next cycle, and a second program is written.
//  - CHECKSUM_EN: stream 01 00 13 05 10 00 then 06 -> done=1. Ending with 07 instead -> err=1,
//    cpu_rst=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
// Latency: n/a (types only).
// Backpressure: n/a. Optional macro LOADER_CHECKSUM_EN adds the CHK state.
package loader_pkg;

  localparam int          BYTES_PER_WORD    = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK  = 3'd4,
`endif
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Purpose: packs accepted bytes little-endian into a word; flags the 4th byte.
// Latency: combinational word_vld_o/word_dat_o on the accepting cycle; caller registers them.
// Backpressure: none of its own; byte_vld_i must already be a completed transfer.
// Ports: clk_i/rst_i (async active-high), clr_i drops any partial word,
//        byte_vld_i/byte_dat_i accepted byte, word_vld_o/word_dat_o completed word.
module word_assembler
  import loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_dat_i,
  output logic             word_vld_o,
  output logic [WIDTH-1:0] word_dat_o
);

  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic             last_lane;

  assign last_lane = (cnt_q == 2'(BYTES_PER_WORD - 1));

  // The current byte lands in the lane selected by the byte counter, so the
  // full word is visible in the same cycle as its last byte.
  always_comb begin
    word_d = word_q;
    word_d[{cnt_q, 3'b000} +: 8] = byte_dat_i;
  end

  assign word_vld_o = byte_vld_i && last_lane;
  assign word_dat_o = word_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (byte_vld_i) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= last_lane ? '0 : word_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Purpose: byte-serial program loader writing little-endian words to instruction memory; holds CPU in reset.
// Latency: mem_we/mem_addr/mem_wdata valid the cycle after the 4th byte of a word is accepted.
// Backpressure: byte_ready is a registered level (LEN0/LEN1/DATA/CHK); stalls on byte_valid are tolerated.
// Ports: CLK, rst (async active-high), start pulse, byte_valid/byte_data/byte_ready stream,
//        mem_we/mem_addr/mem_wdata write port, cpu_rst, done, err status levels.
// Macro LOADER_CHECKSUM_EN: adds a trailing XOR checksum byte checked in the CHK state.
module instr_loader
  import loader_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(DEFAULT_BASE_ADDR),
  parameter int               MAX_WORDS = 1024
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             err
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  loader_state_t    state_q;
  logic [15:0]      len_q;
  logic [15:0]      wcnt_q;
  logic [WIDTH-1:0] next_addr_q;
  logic             byte_ready_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic             cpu_rst_q;
  logic             done_q;
  logic             err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       xor_q;
`endif

  logic             take;
  logic             start_ok;
  logic [15:0]      len_d;
  logic [15:0]      wcnt_d;
  logic             word_vld;
  logic [WIDTH-1:0] word_dat;

  assign take     = byte_valid && byte_ready_q;
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign len_d    = {byte_data, len_q[7:0]};
  assign wcnt_d   = wcnt_q + 16'd1;

  word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk_i      (CLK),
    .rst_i      (rst),
    .clr_i      (start_ok),
    .byte_vld_i (take && (state_q == ST_DATA)),
    .byte_dat_i (byte_data),
    .word_vld_o (word_vld),
    .word_dat_o (word_dat)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      wcnt_q       <= '0;
      next_addr_q  <= BASE_ADDR;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (start_ok) begin
        state_q      <= ST_LEN0;
        len_q        <= '0;
        wcnt_q       <= '0;
        next_addr_q  <= BASE_ADDR;
        byte_ready_q <= 1'b1;
        cpu_rst_q    <= 1'b1;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xor_q        <= '0;
`endif
      end else if (take) begin
        case (state_q)
          ST_LEN0: begin
            len_q[7:0] <= byte_data;
            state_q    <= ST_LEN1;
          end
          ST_LEN1: begin
            len_q[15:8] <= byte_data;
            if (len_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q      <= ST_CHK;
`else
              state_q      <= ST_DONE;
              byte_ready_q <= 1'b0;
              done_q       <= 1'b1;
              cpu_rst_q    <= 1'b0;
`endif
            end else if (len_d > MAX_LEN) begin
              state_q      <= ST_ERR;
              byte_ready_q <= 1'b0;
              err_q        <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ byte_data;
`endif
            if (word_vld) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= next_addr_q;
              mem_wdata_q <= word_dat;
              next_addr_q <= next_addr_q + WIDTH'(BYTES_PER_WORD);
              wcnt_q      <= wcnt_d;
              if (wcnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                state_q      <= ST_CHK;
`else
                state_q      <= ST_DONE;
                byte_ready_q <= 1'b0;
                done_q       <= 1'b1;
                cpu_rst_q    <= 1'b0;
`endif
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHK: begin
            byte_ready_q <= 1'b0;
            if (byte_data == xor_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          MAXW = 1024;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_rst, done, err;
  logic [31:0] mem_addr, mem_wdata;

  instr_loader #(.WIDTH(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          gap_max  = 0;
  bit          drv_timeout = 0;
  bit          we_prev = 0;
  bit          we_double = 0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] exp_words[$];
  logic [7:0]  stream[$];

  // Memory-side observer: records every write strobe seen between edges.
  always @(negedge CLK) begin
    if (mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
    end
    if (mem_we && we_prev) we_double = 1;
    we_prev = mem_we;
  end

  // Reference stream: length LSB first, then each word LSB first, then the XOR of payload bytes.
  function automatic void build_stream(input int n, input bit with_chk);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    foreach (exp_words[i]) begin
      w = exp_words[i];
      for (int k = 0; k < 4; k++) begin
        stream.push_back(8'(w >> (8 * k)));
        x = x ^ 8'(w >> (8 * k));
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (with_chk) stream.push_back(x);
`else
    if (with_chk) x = 8'h00;
`endif
  endfunction

  function automatic void random_words(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
  endfunction

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    we_double = 0;
    drv_timeout = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int guard;
    repeat ($urandom_range(0, gap_max)) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(negedge CLK);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    forever begin
      acc = byte_ready;
      @(negedge CLK);
      if (acc) break;
      guard++;
      if (guard > 50) begin
        drv_timeout = 1;
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) send_byte(stream[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit to);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      if (done || err) begin
        to = 0;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({byte_ready, mem_we, cpu_rst, done, err} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy/we/cpurst/done/err=%b want 00100", {byte_ready, mem_we, cpu_rst, done, err});
    end
    n_checks++;
    if (mem_addr !== BASE) begin n_fail++; $display("FAIL reset_addr got %h want %h", mem_addr, BASE); end
    n_checks++;
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    rst = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({byte_ready, cpu_rst, done} !== 3'b010) begin
      n_fail++;
      $display("FAIL idle_ctrl got rdy/cpurst/done=%b want 010", {byte_ready, cpu_rst, done});
    end
  endtask

  task automatic test_basic();
    bit to;
    clear_obs();
    gap_max = 0;
    exp_words.delete();
    exp_words.push_back(32'h00100513);
    build_stream(1, 1);
    pulse_start();
    send_range(0, 6);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== BASE || mem_wdata !== 32'h00100513) begin
      n_fail++;
      $display("FAIL basic_write got we=%b addr=%h data=%h want 1 %h 00100513", mem_we, mem_addr, mem_wdata, BASE);
    end
`ifdef LOADER_CHECKSUM_EN
    n_checks++;
    if (done !== 1'b0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_chk_wait got done=%b rdy=%b want 0 1", done, byte_ready);
    end
    send_byte(stream[6]);
`endif
    wait_end(to);
    n_checks++;
    if (to || drv_timeout) begin n_fail++; $display("FAIL basic_timeout got timeout want completion"); end
    n_checks++;
    if ({done, err, cpu_rst, byte_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_status got done/err/cpurst/rdy=%b want 1000", {done, err, cpu_rst, byte_ready});
    end
    @(negedge CLK);
    n_checks++;
    if (obs_addr.size() != 1 || we_double) begin
      n_fail++;
      $display("FAIL basic_count got %0d writes double=%0d want 1 0", obs_addr.size(), we_double);
    end
  endtask

  // Random words with random stalls; compares the observed write list with the model.
  task automatic run_random(input string name, input int n, input int gap);
    bit to;
    clear_obs();
    gap_max = gap;
    random_words(n);
    build_stream(n, 1);
    pulse_start();
    send_range(0, stream.size());
    wait_end(to);
    repeat (2) @(negedge CLK);
    n_checks++;
    if (to || drv_timeout || done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status got to=%0d done=%b err=%b cpurst=%b want 0 1 0 0", name, to | drv_timeout, done, err, cpu_rst);
    end
    n_checks++;
    if (obs_addr.size() != n || we_double) begin
      n_fail++;
      $display("FAIL %s_count got %0d writes double=%0d want %0d 0", name, obs_addr.size(), we_double, n);
    end
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== BASE + 32'(4 * i) || obs_data[i] !== exp_words[i]) begin
        n_fail++;
        $display("FAIL %s_word%0d got %h:%h want %h:%h", name, i, obs_addr[i], obs_data[i], BASE + 32'(4 * i), exp_words[i]);
      end
    end
  endtask

  task automatic test_random();
    run_random("n3", 3, 3);
    for (int p = 0; p < 3; p++) run_random("rnd", $urandom_range(1, 8), 2);
  endtask

  task automatic test_zero_and_max();
    run_random("zero", 0, 1);
    run_random("max", MAXW, 0);
  endtask

  task automatic test_too_big();
    clear_obs();
    gap_max = 1;
    exp_words.delete();
    build_stream(MAXW + 1, 0);
    pulse_start();
    send_range(0, 2);
    n_checks++;
    if ({err, done, cpu_rst, byte_ready} !== 4'b1010 || drv_timeout) begin
      n_fail++;
      $display("FAIL too_big_status got err/done/cpurst/rdy=%b want 1010", {err, done, cpu_rst, byte_ready});
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (obs_addr.size() != 0) begin n_fail++; $display("FAIL too_big_writes got %0d want 0", obs_addr.size()); end
  endtask

  task automatic test_midreset();
    clear_obs();
    gap_max = 1;
    random_words(2);
    build_stream(2, 1);
    pulse_start();
    send_range(0, 8);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({byte_ready, mem_we, cpu_rst, done, err} !== 5'b00100 || mem_addr !== BASE || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs got ctrl=%b addr=%h data=%h want 00100 %h 0",
               {byte_ready, mem_we, cpu_rst, done, err}, mem_addr, mem_wdata, BASE);
    end
    n_checks++;
    if (obs_addr.size() != 1) begin n_fail++; $display("FAIL midreset_prior_writes got %0d want 1", obs_addr.size()); end
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    run_random("after_rst", 2, 2);
  endtask

  task automatic test_restart();
    bit to;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) begin
      @(negedge CLK);
      n_checks++;
      if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL done_not_ready got %b want 0", byte_ready); end
    end
    byte_valid = 1'b0;
    clear_obs();
    gap_max = 1;
    random_words(2);
    build_stream(2, 1);
    pulse_start();
    n_checks++;
    if ({cpu_rst, done, byte_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL restart_ctrl got cpurst/done/rdy=%b want 101", {cpu_rst, done, byte_ready});
    end
    send_range(0, 6);
    pulse_start();
    send_range(6, stream.size());
    wait_end(to);
    repeat (2) @(negedge CLK);
    n_checks++;
    if (to || drv_timeout || done !== 1'b1 || obs_addr.size() != 2) begin
      n_fail++;
      $display("FAIL restart_status got to=%0d done=%b writes=%0d want 0 1 2", to | drv_timeout, done, obs_addr.size());
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== BASE + 32'(4 * i) || obs_data[i] !== exp_words[i]) begin
        n_fail++;
        $display("FAIL restart_word%0d got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], BASE + 32'(4 * i), exp_words[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    bit to;
    clear_obs();
    gap_max = 0;
    exp_words.delete();
    exp_words.push_back(32'h00100513);
    build_stream(1, 0);
    stream.push_back(8'h07);
    pulse_start();
    send_range(0, stream.size());
    wait_end(to);
    @(negedge CLK);
    n_checks++;
    if (to || drv_timeout || {err, done, cpu_rst} !== 3'b101 || obs_addr.size() != 1) begin
      n_fail++;
      $display("FAIL chk_bad got to=%0d err/done/cpurst=%b writes=%0d want 0 101 1",
               to | drv_timeout, {err, done, cpu_rst}, obs_addr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_zero_and_max();
    test_too_big();
    test_midreset();
    test_restart();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
